// File: rtl/instr_fetch_unit.sv
// Fetch stage: turns PC word addresses into {pc, instruction} pairs queued for decode,
// with one outstanding memory read at a time and flush support for taken branches.
module instr_fetch_unit #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic              pc_valid,
  output logic              pc_ready,
  input  logic              flush,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              ir_valid,
  input  logic              ir_ready,
  output logic [DATA_W-1:0] ir_out,
  output logic [ADDR_W-1:0] ir_pc
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, BUSY, DISCARD} state_t;

  state_t            state;
  logic [CW-1:0]     count;
  logic [PW-1:0]     wptr;
  logic [PW-1:0]     rptr;
  logic [DATA_W-1:0] q_data [DEPTH];
  logic [ADDR_W-1:0] q_pc   [DEPTH];
  logic              push;
  logic              pop;

  // Only accept a new PC with nothing outstanding and guaranteed room, so the queue never overflows.
  assign pc_ready = !rst && (state == IDLE) && !flush && (count < CW'(DEPTH));
  assign push     = (state == BUSY) && mem_ack && !flush;
  assign pop      = ir_valid && ir_ready && !flush;
  assign ir_valid = (count != '0);
  assign ir_out   = q_data[rptr];
  assign ir_pc    = q_pc[rptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      mem_req  <= 1'b0;
      mem_addr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pc_valid && pc_ready) begin
            mem_addr <= pc_in;
            mem_req  <= 1'b1;
            state    <= BUSY;
          end
        end
        BUSY: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            state   <= IDLE;
          end else if (flush) begin
            state <= DISCARD;
          end
        end
        DISCARD: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            state   <= IDLE;
          end
        end
        default: begin
          mem_req <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  // Flush voids any push or pop in the same cycle; stale storage is left in place.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      wptr  <= '0;
      rptr  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_data[i] <= '0;
        q_pc[i]   <= '0;
      end
    end else if (flush) begin
      count <= '0;
      wptr  <= '0;
      rptr  <= '0;
    end else begin
      if (push) begin
        q_data[wptr] <= mem_rdata;
        q_pc[wptr]   <= mem_addr;
        wptr         <= wptr + PW'(1);
      end
      if (pop) begin
        rptr <= rptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: a table of per-cycle vectors plus
// hand-written sequences for slow memory, flush and reset-mid-fetch cases.
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst;
  logic [31:0] pc_in;
  logic        pc_valid;
  logic        pc_ready;
  logic        flush;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        ir_valid;
  logic        ir_ready;
  logic [31:0] ir_out;
  logic [31:0] ir_pc;

  int total;
  int passed;

  typedef struct {
    logic        rst;
    logic        pv;
    logic [31:0] pc;
    logic        fl;
    logic        ack;
    logic [31:0] rd;
    logic        irr;
    logic        e_rdy;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_irv;
    logic [31:0] e_out;
    logic [31:0] e_pc;
    logic        dchk;
  } vec_t;

  localparam int NV = 24;
  vec_t vecs [NV];

  instr_fetch_unit #(.ADDR_W(32), .DATA_W(32), .DEPTH(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .pc_in     (pc_in),
    .pc_valid  (pc_valid),
    .pc_ready  (pc_ready),
    .flush     (flush),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .ir_valid  (ir_valid),
    .ir_ready  (ir_ready),
    .ir_out    (ir_out),
    .ir_pc     (ir_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mkVec(input logic r, input logic pv, input logic [31:0] pc,
                                 input logic fl, input logic ack, input logic [31:0] rd,
                                 input logic irr, input logic e_rdy, input logic e_req,
                                 input logic [31:0] e_addr, input logic e_irv,
                                 input logic [31:0] e_out, input logic [31:0] e_pc,
                                 input logic dchk);
    vec_t v;
    v.rst = r; v.pv = pv; v.pc = pc; v.fl = fl; v.ack = ack; v.rd = rd; v.irr = irr;
    v.e_rdy = e_rdy; v.e_req = e_req; v.e_addr = e_addr; v.e_irv = e_irv;
    v.e_out = e_out; v.e_pc = e_pc; v.dchk = dchk;
    return v;
  endfunction

  task automatic applyStimulus(input logic r, input logic pv, input logic [31:0] pc,
                               input logic fl, input logic ack, input logic [31:0] rd,
                               input logic irr);
    @(negedge clk);
    rst       = r;
    pc_valid  = pv;
    pc_in     = pc;
    flush     = fl;
    mem_ack   = ack;
    mem_rdata = rd;
    ir_ready  = irr;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) begin
      passed++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  initial begin
    total = 0;
    passed = 0;
    rst = 1'b1; pc_valid = 1'b0; pc_in = '0; flush = 1'b0;
    mem_ack = 1'b0; mem_rdata = '0; ir_ready = 1'b0;
    repeat (2) @(posedge clk);

    // Reset, zero-wait stream, backpressure and idle-ack vectors; one row per cycle.
    vecs[0]  = mkVec(1,1,7,0,0,0,0,           0,0,0,0,0,0,1);
    vecs[1]  = mkVec(0,0,0,0,0,0,0,           1,0,0,0,0,0,1);
    vecs[2]  = mkVec(0,1,0,0,0,0,1,           1,0,0,0,0,0,0);
    vecs[3]  = mkVec(0,1,1,0,1,32'h1000,1,    0,1,0,0,0,0,0);
    vecs[4]  = mkVec(0,1,1,0,0,0,1,           1,0,0,1,32'h1000,0,0);
    vecs[5]  = mkVec(0,1,2,0,1,32'h1001,1,    0,1,1,0,0,0,0);
    vecs[6]  = mkVec(0,1,2,0,0,0,1,           1,0,0,1,32'h1001,1,0);
    vecs[7]  = mkVec(0,1,3,0,1,32'h1002,1,    0,1,2,0,0,0,0);
    vecs[8]  = mkVec(0,1,3,0,0,0,1,           1,0,0,1,32'h1002,2,0);
    vecs[9]  = mkVec(0,0,0,0,1,32'h1003,1,    0,1,3,0,0,0,0);
    vecs[10] = mkVec(0,0,0,0,0,0,1,           1,0,0,1,32'h1003,3,0);
    vecs[11] = mkVec(0,0,0,0,0,0,0,           1,0,0,0,0,0,0);
    vecs[12] = mkVec(0,1,0,0,0,0,0,           1,0,0,0,0,0,0);
    vecs[13] = mkVec(0,1,1,0,1,32'h2000,0,    0,1,0,0,0,0,0);
    vecs[14] = mkVec(0,1,1,0,0,0,0,           1,0,0,1,32'h2000,0,0);
    vecs[15] = mkVec(0,1,2,0,1,32'h2001,0,    0,1,1,1,32'h2000,0,0);
    vecs[16] = mkVec(0,1,2,0,0,0,0,           0,0,0,1,32'h2000,0,0);
    vecs[17] = mkVec(0,1,2,0,0,0,1,           0,0,0,1,32'h2000,0,0);
    vecs[18] = mkVec(0,1,2,0,0,0,1,           1,0,0,1,32'h2001,1,0);
    vecs[19] = mkVec(0,0,0,0,1,32'h2002,0,    0,1,2,0,0,0,0);
    vecs[20] = mkVec(0,0,0,0,0,0,1,           1,0,0,1,32'h2002,2,0);
    vecs[21] = mkVec(0,0,0,0,0,0,0,           1,0,0,0,0,0,0);
    vecs[22] = mkVec(0,0,0,0,1,32'h0BAD,0,    1,0,0,0,0,0,0);
    vecs[23] = mkVec(0,0,0,0,0,0,0,           1,0,0,0,0,0,0);

    for (int i = 0; i < NV; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].pv, vecs[i].pc, vecs[i].fl,
                    vecs[i].ack, vecs[i].rd, vecs[i].irr);
      checkOutput($sformatf("v%0d.pc_ready", i), 32'(pc_ready), 32'(vecs[i].e_rdy));
      checkOutput($sformatf("v%0d.mem_req", i),  32'(mem_req),  32'(vecs[i].e_req));
      checkOutput($sformatf("v%0d.ir_valid", i), 32'(ir_valid), 32'(vecs[i].e_irv));
      if (vecs[i].e_req || vecs[i].dchk)
        checkOutput($sformatf("v%0d.mem_addr", i), mem_addr, vecs[i].e_addr);
      if (vecs[i].e_irv || vecs[i].dchk) begin
        checkOutput($sformatf("v%0d.ir_out", i), ir_out, vecs[i].e_out);
        checkOutput($sformatf("v%0d.ir_pc", i),  ir_pc,  vecs[i].e_pc);
      end
    end

    // Slow memory: ack arrives on the fourth request cycle; a waiting PC must not be taken.
    applyStimulus(0,1,5,0,0,0,0);
    checkOutput("slow.accept", 32'(pc_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0,1,6,0,(i == 3),32'hABCD,0);
      checkOutput($sformatf("slow.req%0d", i),   32'(mem_req),  32'd1);
      checkOutput($sformatf("slow.addr%0d", i),  mem_addr,      32'd5);
      checkOutput($sformatf("slow.ready%0d", i), 32'(pc_ready), 32'd0);
    end
    applyStimulus(0,0,0,0,0,0,1);
    checkOutput("slow.req_drop", 32'(mem_req),  32'd0);
    checkOutput("slow.ir_valid", 32'(ir_valid), 32'd1);
    checkOutput("slow.ir_out",   ir_out,        32'hABCD);
    checkOutput("slow.ir_pc",    ir_pc,         32'd5);
    applyStimulus(0,0,0,0,0,0,0);
    checkOutput("slow.empty", 32'(ir_valid), 32'd0);

    // Flush while BUSY: the late 0xDEAD must be dropped, then PC 20 fetches normally.
    applyStimulus(0,1,8,0,0,0,1);
    checkOutput("fl5.accept", 32'(pc_ready), 32'd1);
    applyStimulus(0,0,0,1,0,0,1);
    checkOutput("fl5.req",   32'(mem_req),  32'd1);
    checkOutput("fl5.addr",  mem_addr,      32'd8);
    checkOutput("fl5.ready", 32'(pc_ready), 32'd0);
    applyStimulus(0,1,20,0,0,0,1);
    checkOutput("fl5.discard_req",   32'(mem_req),  32'd1);
    checkOutput("fl5.discard_ready", 32'(pc_ready), 32'd0);
    applyStimulus(0,1,20,0,1,32'hDEAD,1);
    checkOutput("fl5.ack_ready", 32'(pc_ready), 32'd0);
    applyStimulus(0,1,20,0,0,0,1);
    checkOutput("fl5.no_dead", 32'(ir_valid), 32'd0);
    checkOutput("fl5.idle",    32'(mem_req),  32'd0);
    checkOutput("fl5.ready2",  32'(pc_ready), 32'd1);
    applyStimulus(0,0,0,0,1,32'h3014,1);
    checkOutput("fl5.addr20", mem_addr, 32'd20);
    applyStimulus(0,0,0,0,0,0,1);
    checkOutput("fl5.ir_valid", 32'(ir_valid), 32'd1);
    checkOutput("fl5.ir_out",   ir_out,        32'h3014);
    checkOutput("fl5.ir_pc",    ir_pc,         32'd20);

    // Fill the queue, then flush with ir_ready high; then flush coinciding with mem_ack.
    applyStimulus(0,1,30,0,0,0,0);
    applyStimulus(0,0,0,0,1,32'h30,0);
    applyStimulus(0,1,31,0,0,0,0);
    applyStimulus(0,0,0,0,1,32'h31,0);
    applyStimulus(0,1,32,1,0,0,1);
    checkOutput("fl6.full_ready", 32'(pc_ready), 32'd0);
    checkOutput("fl6.head_valid", 32'(ir_valid), 32'd1);
    checkOutput("fl6.head_pc",    ir_pc,         32'd30);
    applyStimulus(0,0,0,0,0,0,0);
    checkOutput("fl6.emptied", 32'(ir_valid), 32'd0);
    checkOutput("fl6.ready",   32'(pc_ready), 32'd1);
    checkOutput("fl6.noreq",   32'(mem_req),  32'd0);
    applyStimulus(0,1,40,0,0,0,0);
    applyStimulus(0,0,0,1,1,32'hBEEF,0);
    checkOutput("fl6.ack_req",  32'(mem_req), 32'd1);
    checkOutput("fl6.ack_addr", mem_addr,     32'd40);
    applyStimulus(0,0,0,0,0,0,0);
    checkOutput("fl6.no_beef", 32'(ir_valid), 32'd0);
    checkOutput("fl6.idle",    32'(mem_req),  32'd0);
    applyStimulus(0,1,41,0,0,0,0);
    checkOutput("fl6.accept41", 32'(pc_ready), 32'd1);
    applyStimulus(0,0,0,0,1,32'h41,0);
    applyStimulus(0,0,0,0,0,0,1);
    checkOutput("fl6.ir_out41", ir_out, 32'h41);
    checkOutput("fl6.ir_pc41",  ir_pc,  32'd41);

    // Reset mid-fetch abandons the request and a later ack is ignored.
    applyStimulus(0,1,50,0,0,0,0);
    applyStimulus(1,0,0,0,0,0,0);
    checkOutput("rst.busy_req", 32'(mem_req),  32'd1);
    checkOutput("rst.ready",    32'(pc_ready), 32'd0);
    applyStimulus(0,0,0,0,1,32'h50,0);
    checkOutput("rst.req_drop", 32'(mem_req),  32'd0);
    checkOutput("rst.ready2",   32'(pc_ready), 32'd1);
    applyStimulus(0,0,0,0,0,0,0);
    checkOutput("rst.ignored", 32'(ir_valid), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
